// File: rtl/mmio_data_fifo.sv
// mmio_data_fifo: host MMIO data FIFO with a registered one-cycle read port.
// Define MMIO_DATA_FIFO_STATUS_EN to add sticky overflow/underflow flags to status.
module mmio_data_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [63:0]              status
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             w_pop;
    logic             w_push;

    assign full     = r_count == L_DEPTH;
    assign empty    = r_count == '0;
    assign count    = r_count;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    // A pop frees a slot in the same edge, so a full FIFO still accepts a paired push.
    assign w_pop    = rd_en && !empty;
    assign w_push   = wr_en && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                       (w_pop && !w_push) ? r_count - (AW+1)'(1) : r_count;
        end
    end

`ifdef MMIO_DATA_FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_push)
                r_overflow <= 1'b1;
            if (rd_en && empty)
                r_underflow <= 1'b1;
        end
    end

    assign status = {46'b0, r_underflow, r_overflow, 7'b0, 9'(r_count)};
`else
    assign status = {55'b0, 9'(r_count)};
`endif
endmodule

// File: tb/tb_mmio_data_fifo.sv
// tb_mmio_data_fifo: scenario tasks plus random traffic checked against a queue model.
module tb_mmio_data_fifo;
    localparam int W = 64;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic [63:0]   status;

    mmio_data_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .count(count), .status(status)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_of = 1'b0;
    logic         m_uf = 1'b0;
    int           total = 0;
    int           bad = 0;

    function automatic logic [63:0] exp_status();
`ifdef MMIO_DATA_FIFO_STATUS_EN
        return {46'b0, m_uf, m_of, 7'b0, 9'(q.size())};
`else
        return {55'b0, 9'(q.size())};
`endif
    endfunction

    function automatic logic [141:0] exp_state();
        return {m_valid, m_data, 4'(q.size()), q.size() == D, q.size() == 0, exp_status()};
    endfunction

    // One clock with the given requests; the model applies the same request first.
    task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re);
        bit pop_ok, push_ok;
        wr_en = we; wr_data = wd; rd_en = re;
        pop_ok  = re && q.size() != 0;
        push_ok = we && (q.size() < D || pop_ok);
        if (we && !push_ok) m_of = 1'b1;
        if (re && q.size() == 0) m_uf = 1'b1;
        if (pop_ok) m_data = q.pop_front();
        m_valid = pop_ok;
        if (push_ok) q.push_back(wd);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset(input logic we, input logic re);
        rst = 1'b1; wr_en = we; rd_en = re; wr_data = {$urandom, $urandom};
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        q.delete(); m_data = '0; m_valid = 1'b0; m_of = 1'b0; m_uf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        total++;
        if ({rd_valid, rd_data, count, full, empty, status} !== exp_state()) begin
            bad++;
            $display("FAIL reset_state got v=%b d=%h c=%0d f=%b e=%b s=%h", rd_valid, rd_data, count, full, empty, status);
        end
        total++;
        if (status !== 64'd0) begin bad++; $display("FAIL reset_status got %h exp 0", status); end
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_v [3];
        exp_v[0] = 64'h11; exp_v[1] = 64'h22; exp_v[2] = 64'h33;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_v[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v[i]) begin
                bad++; $display("FAIL basic_pop%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, exp_v[i]);
            end
        end
        cycle(1'b0, '0, 1'b0);
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h33 || empty !== 1'b1) begin
            bad++; $display("FAIL basic_hold got v=%b d=%h e=%b exp v=0 d=33 e=1", rd_valid, rd_data, empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, W'(i), 1'b0);
            if (i == 7) begin
                total++;
                if (full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL ovf_full got f=%b c=%0d exp f=1 c=8", full, count); end
            end
        end
        total++;
        if (status !== exp_status() || count !== 4'd8) begin
            bad++; $display("FAIL ovf_status got s=%h c=%0d exp s=%h c=8", status, count, exp_status());
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== W'(i)) begin
                bad++; $display("FAIL ovf_pop%0d got v=%b d=%h exp %h", i, rd_valid, rd_data, W'(i));
            end
        end
    endtask

    task automatic test_underflow();
        logic [W-1:0] prev;
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 64'h5A5A, 1'b0);
        cycle(1'b0, '0, 1'b1);
        prev = rd_data;
        cycle(1'b0, '0, 1'b1);
        total++;
        if (rd_valid !== 1'b0 || rd_data !== prev || count !== 4'd0 || status !== exp_status()) begin
            bad++; $display("FAIL udf_pop got v=%b d=%h c=%0d s=%h exp v=0 d=%h c=0 s=%h", rd_valid, rd_data, count, status, prev, exp_status());
        end
        total++;
`ifdef MMIO_DATA_FIFO_STATUS_EN
        if (status[17] !== 1'b1) begin bad++; $display("FAIL udf_flag got %b exp 1", status[17]); end
`else
        if (status[17] !== 1'b0) begin bad++; $display("FAIL udf_flag got %b exp 0", status[17]); end
`endif
        cycle(1'b1, 64'hBEEF, 1'b1);
        total++;
        if (rd_valid !== 1'b0 || count !== 4'd1 || rd_data !== prev) begin
            bad++; $display("FAIL empty_pushpop got v=%b c=%0d d=%h exp v=0 c=1 d=%h", rd_valid, count, rd_data, prev);
        end
        cycle(1'b0, '0, 1'b1);
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 64'hBEEF) begin
            bad++; $display("FAIL empty_pushpop_out got v=%b d=%h exp v=1 d=beef", rd_valid, rd_data);
        end
    endtask

    task automatic test_full_simul();
        logic [W-1:0] first;
        do_reset(1'b0, 1'b0);
        first = {$urandom, $urandom};
        cycle(1'b1, first, 1'b0);
        for (int i = 1; i < 8; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0);
        cycle(1'b1, 64'hAA, 1'b1);
        total++;
        if (rd_valid !== 1'b1 || rd_data !== first || count !== 4'd8 || full !== 1'b1) begin
            bad++; $display("FAIL full_simul got v=%b d=%h c=%0d exp v=1 d=%h c=8", rd_valid, rd_data, count, first);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_data !== m_data || rd_valid !== 1'b1) begin
                bad++; $display("FAIL full_drain%0d got d=%h v=%b exp d=%h", i, rd_data, rd_valid, m_data);
            end
        end
        total++;
        if (rd_data !== 64'hAA || empty !== 1'b1) begin bad++; $display("FAIL full_last got d=%h e=%b exp d=aa e=1", rd_data, empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, W'(32'h100 + i), 1'b0);
            cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== W'(32'h100 + i) || count !== 4'd0) begin
                bad++; $display("FAIL wrap%0d got v=%b d=%h c=%0d exp d=%h", i, rd_valid, rd_data, count, W'(32'h100 + i));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0);
        cycle(1'b1, 64'h77, 1'b1);
        do_reset(1'b1, 1'b1);
        total++;
        if (status !== 64'd0 || count !== 4'd0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_state got s=%h c=%0d v=%b exp 0", status, count, rd_valid);
        end
        cycle(1'b0, '0, 1'b1);
        total++;
        if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 64'd0 || status !== exp_status()) begin
            bad++; $display("FAIL rstmid_pop got v=%b c=%0d d=%h s=%h exp s=%h", rd_valid, count, rd_data, status, exp_status());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset(1'($urandom), 1'($urandom));
            else cycle(1'($urandom_range(0, 99) < 55), {$urandom, $urandom}, 1'($urandom_range(0, 99) < 45));
            total++;
            if ({rd_valid, rd_data, count, full, empty, status} !== exp_state()) begin
                bad++; $display("FAIL random%0d got v=%b d=%h c=%0d s=%h exp v=%b d=%h c=%0d s=%h",
                                i, rd_valid, rd_data, count, status, m_valid, m_data, q.size(), exp_status());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
